// File: rtl/dmem_bus_decoder.sv
// Data-memory bus decoder: steers CPU loads/stores to the data RAM or the MMIO block,
// flags misaligned/unmapped accesses and aligns/extends the returned load data.
module dmem_bus_decoder #(
    parameter int RAM_WORD_BITS = 14
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [31:0]              i_addr,
    input  logic [31:0]              i_wdata,
    input  logic [1:0]               i_size,
    input  logic                     i_unsigned,
    input  logic                     i_we,
    input  logic                     i_re,
    output logic [31:0]              o_rdata,
    output logic                     o_rvalid,
    output logic                     o_fault,
    output logic [31:0]              o_fault_addr,
    output logic [RAM_WORD_BITS-1:0] o_ram_addr,
    output logic [31:0]              o_ram_wdata,
    output logic [3:0]               o_ram_byte_we,
    output logic                     o_ram_re,
    input  logic [31:0]              i_ram_rdata,
    output logic [25:0]              o_mmio_addr,
    output logic [31:0]              o_mmio_wdata,
    output logic [3:0]               o_mmio_byte_we,
    output logic                     o_mmio_read_en,
    input  logic [31:0]              i_mmio_rdata
);

    logic        hit_mmio, hit_ram, misaligned, bad_size, req, fault_c;
    logic        go, store_go, load_go;
    logic [3:0]  lane_we;
    logic [31:0] wdata_rep;

    logic        valid_q, mmio_q, uns_q, fault_q;
    logic [1:0]  off_q, size_q;
    logic [31:0] fault_addr_q;

    logic [31:0] sel_rdata, shifted, ext;

    assign hit_mmio   = (i_addr[31:28] == 4'h8);
    assign hit_ram    = (i_addr[31:28] == 4'h0) && (i_addr[27:RAM_WORD_BITS+2] == '0);
    assign misaligned = ((i_size == 2'd1) && i_addr[0]) ||
                        ((i_size == 2'd2) && (i_addr[1:0] != 2'b00));
    assign bad_size   = (i_size == 2'd3);
    assign req        = i_we | i_re;
    assign fault_c    = req & ((~hit_mmio & ~hit_ram) | misaligned | bad_size);

    // Reset and faults both suppress every strobe and read enable.
    assign go       = ~i_rst & ~fault_c;
    assign store_go = go & i_we;
    assign load_go  = go & i_re & ~i_we;

    always_comb begin
        lane_we   = 4'b0000;
        wdata_rep = i_wdata;
        case (i_size)
            2'd0: begin
                lane_we   = 4'b0001 << i_addr[1:0];
                wdata_rep = {4{i_wdata[7:0]}};
            end
            2'd1: begin
                lane_we   = 4'b0011 << i_addr[1:0];
                wdata_rep = {2{i_wdata[15:0]}};
            end
            2'd2:    lane_we = 4'b1111;
            default: lane_we = 4'b0000;
        endcase
    end

    assign o_ram_addr     = i_addr[RAM_WORD_BITS+1:2];
    assign o_mmio_addr    = i_addr[27:2];
    assign o_ram_wdata    = wdata_rep;
    assign o_mmio_wdata   = wdata_rep;
    assign o_ram_byte_we  = (store_go & hit_ram)  ? lane_we : 4'b0000;
    assign o_mmio_byte_we = (store_go & hit_mmio) ? lane_we : 4'b0000;
    assign o_ram_re       = load_go & hit_ram;
    assign o_mmio_read_en = load_go & hit_mmio;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q      <= 1'b0;
            mmio_q       <= 1'b0;
            off_q        <= 2'b00;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'h0;
        end else begin
            valid_q <= load_go;
            mmio_q  <= hit_mmio;
            off_q   <= i_addr[1:0];
            size_q  <= i_size;
            uns_q   <= i_unsigned;
            fault_q <= fault_c;
            if (fault_c) begin
                fault_addr_q <= i_addr;
            end
        end
    end

    assign sel_rdata = mmio_q ? i_mmio_rdata : i_ram_rdata;
    assign shifted   = sel_rdata >> {off_q, 3'b000};

    always_comb begin
        case (size_q)
            2'd0:    ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            2'd1:    ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    assign o_rdata      = valid_q ? ext : 32'h0;
    assign o_rvalid     = valid_q;
    assign o_fault      = fault_q;
    assign o_fault_addr = fault_addr_q;

endmodule

// File: tb/tb_dmem_bus_decoder.sv
// Bench for dmem_bus_decoder: directed scenarios plus random traffic checked against
// a byte-level memory model with RAM and MMIO stubs attached to the DUT.
module tb_dmem_bus_decoder;

    logic        i_clk = 1'b0;
    logic        i_rst, i_unsigned, i_we, i_re;
    logic [31:0] i_addr, i_wdata, i_ram_rdata, i_mmio_rdata;
    logic [1:0]  i_size;
    logic [31:0] o_rdata, o_fault_addr, o_ram_wdata, o_mmio_wdata;
    logic        o_rvalid, o_fault, o_ram_re, o_mmio_read_en;
    logic [13:0] o_ram_addr;
    logic [25:0] o_mmio_addr;
    logic [3:0]  o_ram_byte_we, o_mmio_byte_we;

    int n_chk = 0;
    int n_bad = 0;
    bit have_state = 0;

    logic [31:0] stub [0:16383];
    bit          stub_init = 0;
    logic [7:0]  mem_m [0:65535];

    logic        exp_rvalid, exp_fault;
    logic [31:0] exp_rdata, exp_faddr;

    dmem_bus_decoder dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_size(i_size), .i_unsigned(i_unsigned), .i_we(i_we), .i_re(i_re),
        .o_rdata(o_rdata), .o_rvalid(o_rvalid), .o_fault(o_fault),
        .o_fault_addr(o_fault_addr), .o_ram_addr(o_ram_addr),
        .o_ram_wdata(o_ram_wdata), .o_ram_byte_we(o_ram_byte_we),
        .o_ram_re(o_ram_re), .i_ram_rdata(i_ram_rdata),
        .o_mmio_addr(o_mmio_addr), .o_mmio_wdata(o_mmio_wdata),
        .o_mmio_byte_we(o_mmio_byte_we), .o_mmio_read_en(o_mmio_read_en),
        .i_mmio_rdata(i_mmio_rdata)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] mmio_val(input logic [25:0] a);
        return {a, 6'b000000} ^ 32'hC3A5_5A3C;
    endfunction

    // RAM stub: 1-cycle read latency, byte-strobed writes
    always @(posedge i_clk) begin
        if (!stub_init) begin
            for (int i = 0; i < 16384; i++) stub[i] <= 32'h0;
            stub_init <= 1'b1;
        end else begin
            if (o_ram_re) i_ram_rdata <= stub[o_ram_addr];
            for (int b = 0; b < 4; b++)
                if (o_ram_byte_we[b]) stub[o_ram_addr][8*b +: 8] <= o_ram_wdata[8*b +: 8];
        end
    end

    always @(posedge i_clk) begin
        if (o_mmio_read_en) i_mmio_rdata <= mmio_val(o_mmio_addr);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_ram_a(input logic [31:0] a);
        return a < 32'h0001_0000;
    endfunction

    function automatic bit is_mmio_a(input logic [31:0] a);
        return (a >> 28) == 32'h8;
    endfunction

    function automatic bit faults(input logic [31:0] a, input logic [1:0] sz,
                                  input bit we, input bit re);
        if (!(we || re)) return 0;
        if (!is_ram_a(a) && !is_mmio_a(a)) return 1;
        if (sz == 2'd3) return 1;
        if (sz == 2'd1 && (a % 2) != 0) return 1;
        if (sz == 2'd2 && (a % 4) != 0) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                               input bit uns);
        int nb = 1 << sz;
        logic [31:0] v = 0;
        logic [31:0] w = mmio_val(a[27:2]);
        logic [7:0]  by;
        for (int k = 0; k < nb; k++) begin
            if (is_ram_a(a)) by = mem_m[int'(a % 65536) + k];
            else             by = 8'(w >> (8 * ((a % 4) + k)));
            v = v | ({24'h0, by} << (8 * k));
        end
        if (nb < 4 && !uns && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        return v;
    endfunction

    task automatic set_req(input bit rst, input logic [31:0] a, input logic [31:0] wd,
                           input logic [1:0] sz, input bit uns, input bit we, input bit re);
        bit f, ok;
        int nb, m;
        logic [3:0]  mask;
        logic [31:0] ewd;
        i_rst = rst; i_addr = a; i_wdata = wd; i_size = sz;
        i_unsigned = uns; i_we = we; i_re = re;
        #1;
        if (have_state) begin
            chk("rvalid", {31'h0, o_rvalid}, {31'h0, exp_rvalid});
            chk("rdata", o_rdata, exp_rdata);
            chk("fault", {31'h0, o_fault}, {31'h0, exp_fault});
            chk("fault_addr", o_fault_addr, exp_faddr);
        end
        f  = faults(a, sz, we, re);
        ok = !rst && !f;
        nb = 1 << sz;
        m  = ((1 << nb) - 1) << (a % 4);
        mask = m[3:0];
        chk("ram_addr", {18'h0, o_ram_addr}, (a >> 2) % 16384);
        chk("mmio_addr", {6'h0, o_mmio_addr}, (a >> 2) % 32'h0400_0000);
        chk("ram_we", {28'h0, o_ram_byte_we}, (ok && we && is_ram_a(a)) ? {28'h0, mask} : 32'h0);
        chk("mmio_we", {28'h0, o_mmio_byte_we}, (ok && we && is_mmio_a(a)) ? {28'h0, mask} : 32'h0);
        chk("ram_re", {31'h0, o_ram_re}, {31'h0, ok && re && !we && is_ram_a(a)});
        chk("mmio_re", {31'h0, o_mmio_read_en}, {31'h0, ok && re && !we && is_mmio_a(a)});
        if (sz != 2'd3) begin
            if (sz == 2'd0)      ewd = {24'h0, wd[7:0]} * 32'h0101_0101;
            else if (sz == 2'd1) ewd = {16'h0, wd[15:0]} * 32'h0001_0001;
            else                 ewd = wd;
            chk("ram_wdata", o_ram_wdata, ewd);
            chk("mmio_wdata", o_mmio_wdata, ewd);
        end
    endtask

    task automatic step();
        bit f, nv, nf;
        logic [31:0] nd, na;
        f  = faults(i_addr, i_size, i_we, i_re);
        nf = !i_rst && f;
        nv = !i_rst && i_re && !i_we && !f;
        na = i_rst ? 32'h0 : (f ? i_addr : exp_faddr);
        nd = nv ? model_load(i_addr, i_size, i_unsigned) : 32'h0;
        if (!i_rst && i_we && !f && is_ram_a(i_addr))
            for (int k = 0; k < (1 << i_size); k++)
                mem_m[int'(i_addr % 65536) + k] = i_wdata[8*k +: 8];
        @(posedge i_clk);
        exp_rvalid = nv; exp_fault = nf; exp_faddr = na; exp_rdata = nd;
        have_state = 1;
        @(negedge i_clk);
    endtask

    task automatic idle();
        set_req(0, 32'h0, 32'h0, 2'd0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int r;
        bit we, re;
        for (int i = 0; i < 65536; i++) mem_m[i] = 8'h0;
        @(negedge i_clk);

        // reset cycle with a load and then with a faulting store
        set_req(1, 32'h0, 32'h0, 2'd2, 0, 0, 1);
        chk("t6_rst_ram_re", {31'h0, o_ram_re}, 32'h0);
        step();
        set_req(1, 32'h4000_0000, 32'h1, 2'd2, 0, 1, 0);
        step();
        idle();
        chk("rst_no_fault", {31'h0, o_fault}, 32'h0);
        step();

        set_req(0, 32'h100, 32'h1122_3344, 2'd2, 0, 1, 0);
        chk("t1_we", {28'h0, o_ram_byte_we}, 32'hF);
        chk("t1_addr", {18'h0, o_ram_addr}, 32'h40);
        step();
        set_req(0, 32'h100, 32'h0, 2'd2, 0, 0, 1);
        step();
        idle();
        chk("t1_rdata", o_rdata, 32'h1122_3344);
        chk("t1_rvalid", {31'h0, o_rvalid}, 32'h1);
        step();

        set_req(0, 32'h103, 32'h0000_00A5, 2'd0, 0, 1, 0);
        chk("t2_wdata", o_ram_wdata, 32'hA5A5_A5A5);
        chk("t2_we", {28'h0, o_ram_byte_we}, 32'h8);
        step();
        set_req(0, 32'h103, 32'h0, 2'd0, 0, 0, 1);
        step();
        set_req(0, 32'h103, 32'h0, 2'd0, 1, 0, 1);
        chk("t2_lb", o_rdata, 32'hFFFF_FFA5);
        step();
        idle();
        chk("t2_lbu", o_rdata, 32'h0000_00A5);
        step();

        set_req(0, 32'h8000_0014, 32'h0, 2'd2, 0, 0, 1);
        chk("t3_mmio_re", {31'h0, o_mmio_read_en}, 32'h1);
        chk("t3_mmio_addr", {6'h0, o_mmio_addr}, 32'h5);
        chk("t3_ram_re", {31'h0, o_ram_re}, 32'h0);
        step();
        idle();
        chk("t3_rdata", o_rdata, mmio_val(26'd5));
        step();

        set_req(0, 32'h8000_0001, 32'h0, 2'd1, 0, 0, 1);
        chk("t4_mmio_re", {31'h0, o_mmio_read_en}, 32'h0);
        step();
        idle();
        chk("t4_fault", {31'h0, o_fault}, 32'h1);
        chk("t4_faddr", o_fault_addr, 32'h8000_0001);
        chk("t4_rvalid", {31'h0, o_rvalid}, 32'h0);
        step();
        idle();
        chk("t4_pulse", {31'h0, o_fault}, 32'h0);
        step();

        set_req(0, 32'h4000_0000, 32'hDEAD_BEEF, 2'd2, 0, 1, 0);
        chk("t5_ram_we", {28'h0, o_ram_byte_we}, 32'h0);
        chk("t5_mmio_we", {28'h0, o_mmio_byte_we}, 32'h0);
        step();
        set_req(0, 32'h100, 32'h0, 2'd2, 0, 0, 1);
        chk("t5_fault", {31'h0, o_fault}, 32'h1);
        step();
        idle();
        chk("t5_rdata", o_rdata, 32'hA522_3344);
        step();

        set_req(0, 32'h0, 32'hBEEF_1234, 2'd2, 0, 1, 0);
        step();
        set_req(0, 32'h4, 32'h9ABC_5678, 2'd2, 0, 1, 0);
        step();
        set_req(1, 32'h0, 32'h0, 2'd2, 0, 0, 1);
        chk("t6_ram_re", {31'h0, o_ram_re}, 32'h0);
        step();
        set_req(0, 32'h2, 32'h0, 2'd1, 0, 0, 1);
        chk("t6_rvalid", {31'h0, o_rvalid}, 32'h0);
        step();
        set_req(0, 32'h6, 32'h0, 2'd1, 1, 0, 1);
        chk("t6_lh", o_rdata, 32'hFFFF_BEEF);
        step();
        idle();
        chk("t6_lhu", o_rdata, 32'h0000_9ABC);
        step();

        for (int n = 0; n < 1500; n++) begin
            case ($urandom % 10)
                0, 1, 2, 3, 4, 5: a = $urandom % 256;
                6:       a = 32'h8000_0000 | ($urandom % 64);
                7:       a = {4'h8, 28'($urandom)};
                8:       a = ($urandom % 2) ? (32'h4000_0000 ^ ($urandom % 4096))
                                            : (32'h0001_0000 + ($urandom % 32'h00FF_0000));
                default: a = 32'h0000_FFF8 + ($urandom % 12);
            endcase
            sz = ($urandom % 8 < 7) ? 2'($urandom % 3) : 2'd3;
            r  = $urandom % 8;
            we = (r <= 2) || (r == 6);
            re = (r >= 3 && r <= 6);
            set_req(($urandom % 50) == 0, a, $urandom, sz, 1'($urandom % 2), we, re);
            step();
        end
        idle();
        step();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
